// File: rtl/led_sequencer.sv
// LED pattern sequencer: five debounced push-buttons select, pace, pause and
// restart one of five animations shown on six active-low LEDs.
//
//   mode        | meaning
//   ------------+--------------------------------------------------
//   MODE_OFF    | all LEDs dark, pattern pinned at 000000
//   MODE_BLINK  | bit 0 toggles each step
//   MODE_CHASE  | single lit LED rotates left, wrapping
//   MODE_BOUNCE | single lit LED ping-pongs between bit 0 and bit 5
//   MODE_BINARY | pattern counts up in binary, wrapping
module led_sequencer #(
   parameter int TICK_DIV        = 2_700_000,
   parameter int DEBOUNCE_CYCLES = 270_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn_n,
   output logic [5:0] led_n,
   output logic [2:0] mode,
   output logic       paused,
   output logic       slow
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = $clog2(4 * TICK_DIV);

   typedef enum logic [2:0] {
      MODE_OFF    = 3'd0,
      MODE_BLINK  = 3'd1,
      MODE_CHASE  = 3'd2,
      MODE_BOUNCE = 3'd3,
      MODE_BINARY = 3'd4
   } mode_e;

   logic [4:0]    sync1_q;
   logic [4:0]    sync2_q;
   logic [4:0]    lvl;
   logic [4:0]    deb_d, deb_q;
   logic [4:0]    pulse_d, pulse_q;
   logic [DW-1:0] dcnt_d [5];
   logic [DW-1:0] dcnt_q [5];

   logic          next_p, prev_p, speed_p, pause_p, restart_p;
   logic          mode_chg;
   logic          tick;
   mode_e         mode_fwd, mode_back;
   mode_e         mode_d, mode_q;
   logic [5:0]    pat_d, pat_q;
   logic          dir_down_d, dir_down_q;
   logic          slow_d, slow_q;
   logic          paused_d, paused_q;
   logic [PW-1:0] presc_d, presc_q;
   logic [PW-1:0] period_last;

   function automatic logic [5:0] entry_pat(input mode_e m);
      return (m == MODE_BLINK || m == MODE_CHASE || m == MODE_BOUNCE) ? 6'b000001 : 6'b000000;
   endfunction

   assign lvl = ~sync2_q;

   always_comb begin
      deb_d   = deb_q;
      pulse_d = '0;
      for (int i = 0; i < 5; i++) begin
         dcnt_d[i] = '0;
         if (lvl[i] != deb_q[i]) begin
            if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i]   = lvl[i];
               pulse_d[i] = lvl[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '0;
         pulse_q <= '0;
         for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         pulse_q <= pulse_d;
         for (int i = 0; i < 5; i++) dcnt_q[i] <= dcnt_d[i];
      end
   end

   assign next_p    = pulse_q[0];
   assign prev_p    = pulse_q[1];
   assign speed_p   = pulse_q[2];
   assign pause_p   = pulse_q[3];
   assign restart_p = pulse_q[4];

   always_comb begin
      case (mode_q)
         MODE_OFF:    mode_fwd = MODE_BLINK;
         MODE_BLINK:  mode_fwd = MODE_CHASE;
         MODE_CHASE:  mode_fwd = MODE_BOUNCE;
         MODE_BOUNCE: mode_fwd = MODE_BINARY;
         default:     mode_fwd = MODE_OFF;
      endcase
      case (mode_q)
         MODE_BLINK:  mode_back = MODE_OFF;
         MODE_CHASE:  mode_back = MODE_BLINK;
         MODE_BOUNCE: mode_back = MODE_CHASE;
         MODE_BINARY: mode_back = MODE_BOUNCE;
         default:     mode_back = MODE_BINARY;
      endcase

      // Opposing next/previous pulses cancel out.
      mode_chg = next_p ^ prev_p;
      mode_d   = mode_q;
      if (mode_chg) mode_d = next_p ? mode_fwd : mode_back;

      period_last = slow_q ? PW'(4 * TICK_DIV - 1) : PW'(TICK_DIV - 1);
      tick        = !paused_q && (presc_q == period_last);

      presc_d = presc_q + PW'(1);
      if (mode_chg || restart_p || speed_p) presc_d = '0;
      else if (paused_q)                    presc_d = presc_q;
      else if (tick)                        presc_d = '0;

      slow_d   = slow_q ^ speed_p;
      paused_d = paused_q ^ pause_p;

      pat_d      = pat_q;
      dir_down_d = dir_down_q;
      if (mode_chg) begin
         pat_d      = entry_pat(mode_d);
         dir_down_d = 1'b0;
      end else if (restart_p) begin
         pat_d      = entry_pat(mode_q);
         dir_down_d = 1'b0;
      end else if (tick) begin
         case (mode_q)
            MODE_OFF:    pat_d = '0;
            MODE_BLINK:  pat_d = {5'b00000, ~pat_q[0]};
            MODE_CHASE:  pat_d = {pat_q[4:0], pat_q[5]};
            MODE_BOUNCE: begin
               if (!dir_down_q) begin
                  pat_d = pat_q << 1;
                  if (pat_d == 6'b100000) dir_down_d = 1'b1;
               end else begin
                  pat_d = pat_q >> 1;
                  if (pat_d == 6'b000001) dir_down_d = 1'b0;
               end
            end
            MODE_BINARY: pat_d = pat_q + 6'd1;
            default:     pat_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= MODE_OFF;
         pat_q      <= '0;
         dir_down_q <= 1'b0;
         slow_q     <= 1'b0;
         paused_q   <= 1'b0;
         presc_q    <= '0;
      end else begin
         mode_q     <= mode_d;
         pat_q      <= pat_d;
         dir_down_q <= dir_down_d;
         slow_q     <= slow_d;
         paused_q   <= paused_d;
         presc_q    <= presc_d;
      end
   end

   assign led_n  = ~pat_q;
   assign mode   = mode_q;
   assign paused = paused_q;
   assign slow   = slow_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=8 and DEBOUNCE_CYCLES=4.
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] btn_n = 5'h1F;
   logic [5:0] led_n;
   logic [2:0] mode;
   logic       paused;
   logic       slow;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] CHASE_LED  [6]  = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
   localparam logic [5:0] BOUNCE_LED [11] = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h2F,
                                              6'h37, 6'h3B, 6'h3D, 6'h3E, 6'h3D};

   led_sequencer #(.TICK_DIV(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_n  (btn_n),
      .led_n  (led_n),
      .mode   (mode),
      .paused (paused),
      .slow   (slow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Holds the given buttons long enough for one press; returns just after the edge
   // on which the resulting state change lands, with all buttons released.
   task automatic press(input logic [4:0] mask);
      btn_n = ~mask;
      step(7);
      btn_n = 5'h1F;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      btn_n = 5'($urandom);
      #1;
      check("rst_async_mode", 8'(mode), 8'd0);
      check("rst_async_led", 8'(led_n), 8'h3F);
      repeat (4) begin
         @(negedge clk);
         btn_n = 5'($urandom);
      end
      btn_n = 5'h1F;
      rst_n = 1'b1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic changed;

      do_reset();
      check("rst_led", 8'(led_n), 8'h3F);
      check("rst_mode", 8'(mode), 8'd0);
      check("rst_slow", 8'(slow), 8'd0);
      check("rst_paused", 8'(paused), 8'd0);
      changed = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (led_n !== 6'h3F || mode !== 3'd0) changed = 1'b1;
      end
      check("rst_quiet", 8'(changed), 8'd0);

      btn_n = 5'h1E;
      step(3);
      btn_n = 5'h1F;
      step(10);
      check("glitch_mode", 8'(mode), 8'd0);

      btn_n = 5'h1E;
      step(6);
      check("deb_edge6_mode", 8'(mode), 8'd0);
      step(1);
      check("deb_edge7_mode", 8'(mode), 8'd1);
      check("blink_entry", 8'(led_n), 8'h3E);
      step(7);
      check("blink_hold", 8'(led_n), 8'h3E);
      step(1);
      check("blink_off", 8'(led_n), 8'h3F);
      step(8);
      check("blink_on", 8'(led_n), 8'h3E);
      btn_n = 5'h1F;
      step(10);
      check("release_no_pulse", 8'(mode), 8'd1);

      do_reset();
      press(5'h01);
      step(8);
      press(5'h01);
      check("chase_mode", 8'(mode), 8'd2);
      check("chase_entry", 8'(led_n), 8'h3E);
      for (int i = 0; i < 6; i++) begin
         step(8);
         check("chase_step", 8'(led_n), 8'(CHASE_LED[i]));
      end

      do_reset();
      press(5'h02);
      check("prev_wrap_mode", 8'(mode), 8'd4);
      step(8);
      press(5'h02);
      check("bounce_mode", 8'(mode), 8'd3);
      check("bounce_entry", 8'(led_n), 8'h3E);
      for (int i = 0; i < 11; i++) begin
         step(8);
         check("bounce_step", 8'(led_n), 8'(BOUNCE_LED[i]));
      end
      press(5'h04);
      check("slow_on", 8'(slow), 8'd1);
      check("slow_press_led", 8'(led_n), 8'h3D);
      step(31);
      check("slow_hold", 8'(led_n), 8'h3D);
      step(1);
      check("slow_step1", 8'(led_n), 8'h3B);
      step(32);
      check("slow_step2", 8'(led_n), 8'h37);

      do_reset();
      press(5'h02);
      check("binary_mode", 8'(mode), 8'd4);
      check("binary_entry", 8'(led_n), 8'h3F);
      step(35);
      press(5'h08);
      check("pause_on", 8'(paused), 8'd1);
      check("pause_pat", 8'(led_n), 8'h3A);
      step(200);
      check("pause_hold", 8'(led_n), 8'h3A);
      press(5'h10);
      check("restart_pat", 8'(led_n), 8'h3F);
      check("restart_paused", 8'(paused), 8'd1);
      check("restart_mode", 8'(mode), 8'd4);
      step(8);
      press(5'h08);
      check("pause_off", 8'(paused), 8'd0);
      step(7);
      check("resume_hold", 8'(led_n), 8'h3F);
      step(1);
      check("resume_step", 8'(led_n), 8'h3E);

      do_reset();
      press(5'h03);
      check("both_mode", 8'(mode), 8'd0);
      step(8);
      check("both_mode_later", 8'(mode), 8'd0);

      do_reset();
      press(5'h01);
      step(8);
      press(5'h01);
      check("coinc_pre_mode", 8'(mode), 8'd2);
      step(9);
      press(5'h01);
      check("coinc_mode", 8'(mode), 8'd3);
      check("coinc_entry", 8'(led_n), 8'h3E);
      step(7);
      check("coinc_hold", 8'(led_n), 8'h3E);
      step(1);
      check("coinc_step", 8'(led_n), 8'h3D);

      do_reset();
      btn_n = 5'h1E;
      step(4);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);
      btn_n = 5'h1F;
      step(12);
      check("mid_deb_rst_mode", 8'(mode), 8'd0);
      check("mid_deb_rst_led", 8'(led_n), 8'h3F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
